// File: rtl/ucode_loader.sv
// Writable control store: a byte-serial loader fills a DEPTH-entry control-word RAM.
// The read port decodes store[addr] into the PP control bundle. Optional feature: UCODE_CHECKSUM_EN.
`timescale 1ns/1ps

module ucode_loader #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              load_start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic              cpu_nReset,
    input  logic [ADDR_W-1:0] addr,
    output logic [3:0]        RegAddr,
    output logic [2:0]        ALUCode,
    output logic              Reg_CE,
    output logic              CY_CE,
    output logic              A_CE,
    output logic              ResetCY
);

    localparam int unsigned WORD_W       = 11;
    localparam logic [WORD_W-1:0] DEFAULT_WORD = 11'h7F0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LO,
        S_HI,
        S_WR,
        S_CHK,
        S_DONE
    } state_t;

    state_t              r_state;
    logic                r_err;
    logic                r_byte_ready;
    logic                r_busy;
    logic                r_done;
    logic                r_cpu_nreset;
    logic [ADDR_W-1:0]   r_idx;
    logic [7:0]          r_n;
    logic [7:0]          r_lo;
    logic [2:0]          r_hi;
    logic [WORD_W-1:0]   r_store [DEPTH];
`ifdef UCODE_CHECKSUM_EN
    logic [7:0]          r_chk;
`endif

    state_t              w_state_nxt;
    logic                w_err_nxt;
    logic                w_xfer;
    logic                w_cnt_bad;
    logic                w_hi_bad;
    logic                w_last;
    logic [WORD_W-1:0]   w_rd_word;

    assign w_xfer    = r_byte_ready & byte_valid;
    assign w_cnt_bad = (byte_in == 8'd0) || (32'(byte_in) > DEPTH);
    assign w_hi_bad  = (byte_in[7:3] != 5'd0);
    assign w_last    = ((32'(r_idx) + 32'd1) == 32'(r_n));

    // Next state and next error flag; all state changes in byte states wait for a transfer.
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (load_start) begin
                    w_state_nxt = S_HDR;
                    w_err_nxt   = 1'b0;
                end
            end
            S_HDR: begin
                if (w_xfer) begin
                    if (w_cnt_bad) begin
                        w_state_nxt = S_IDLE;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_LO;
                    end
                end
            end
            S_LO: begin
                if (w_xfer) w_state_nxt = S_HI;
            end
            S_HI: begin
                if (w_xfer) begin
                    if (w_hi_bad) begin
                        w_state_nxt = S_IDLE;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_WR;
                    end
                end
            end
            S_WR: begin
                if (w_last) begin
`ifdef UCODE_CHECKSUM_EN
                    w_state_nxt = S_CHK;
`else
                    w_state_nxt = S_DONE;
`endif
                end else begin
                    w_state_nxt = S_LO;
                end
            end
            S_CHK: begin
`ifdef UCODE_CHECKSUM_EN
                if (w_xfer) begin
                    if (byte_in == r_chk) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_err_nxt   = 1'b1;
                    end
                end
`else
                w_state_nxt = S_IDLE;
`endif
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, registered status outputs (derived from the next state) and the store.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_err        <= 1'b0;
            r_byte_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cpu_nreset <= 1'b0;
            r_idx        <= '0;
            r_n          <= 8'd0;
            r_lo         <= 8'd0;
            r_hi         <= 3'd0;
`ifdef UCODE_CHECKSUM_EN
            r_chk        <= 8'd0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                r_store[i] <= DEFAULT_WORD;
            end
        end else begin
            r_state      <= w_state_nxt;
            r_err        <= w_err_nxt;
            r_byte_ready <= (w_state_nxt == S_HDR) || (w_state_nxt == S_LO) ||
                            (w_state_nxt == S_HI)  || (w_state_nxt == S_CHK);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_done       <= (w_state_nxt == S_DONE);
            r_cpu_nreset <= (w_state_nxt == S_IDLE) && !w_err_nxt;
            case (r_state)
                S_IDLE: begin
                    if (load_start) r_idx <= '0;
                end
                S_HDR: begin
                    if (w_xfer) begin
                        r_n <= byte_in;
`ifdef UCODE_CHECKSUM_EN
                        r_chk <= byte_in;
`endif
                    end
                end
                S_LO: begin
                    if (w_xfer) begin
                        r_lo <= byte_in;
`ifdef UCODE_CHECKSUM_EN
                        r_chk <= r_chk ^ byte_in;
`endif
                    end
                end
                S_HI: begin
                    if (w_xfer) begin
                        r_hi <= byte_in[2:0];
`ifdef UCODE_CHECKSUM_EN
                        r_chk <= r_chk ^ byte_in;
`endif
                    end
                end
                S_WR: begin
                    r_store[r_idx] <= {r_hi, r_lo};
                    r_idx          <= r_idx + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Zero-latency read; indices beyond the store read as the default word.
    generate
        if (DEPTH < (32'd1 << ADDR_W)) begin : g_rd_guard
            assign w_rd_word = (32'(addr) < DEPTH) ? r_store[addr] : DEFAULT_WORD;
        end else begin : g_rd_full
            assign w_rd_word = r_store[addr];
        end
    endgenerate

    assign RegAddr    = w_rd_word[10:7];
    assign ALUCode    = w_rd_word[6:4];
    assign Reg_CE     = w_rd_word[3];
    assign CY_CE      = w_rd_word[2];
    assign A_CE       = w_rd_word[1];
    assign ResetCY    = w_rd_word[0];

    assign byte_ready = r_byte_ready;
    assign load_busy  = r_busy;
    assign load_done  = r_done;
    assign load_err   = r_err;
    assign cpu_nReset = r_cpu_nreset;

endmodule

// File: tb/tb_ucode_loader.sv
// Self-checking bench for ucode_loader: directed vector table, hand-written corner
// sequences and randomized loads against a stream-level reference model.
`timescale 1ns/1ps

module tb_ucode_loader;

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned ADDR_W = 5;
    localparam logic [10:0] DEF    = 11'h7F0;

    logic              clk = 1'b0;
    logic              Reset;
    logic              load_start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              load_busy;
    logic              load_done;
    logic              load_err;
    logic              cpu_nReset;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        RegAddr;
    logic [2:0]        ALUCode;
    logic              Reg_CE, CY_CE, A_CE, ResetCY;

    ucode_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .Reset(Reset), .load_start(load_start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .load_busy(load_busy),
        .load_done(load_done), .load_err(load_err), .cpu_nReset(cpu_nReset),
        .addr(addr), .RegAddr(RegAddr), .ALUCode(ALUCode), .Reg_CE(Reg_CE),
        .CY_CE(CY_CE), .A_CE(A_CE), .ResetCY(ResetCY)
    );

    always #5 clk = ~clk;

    wire [10:0] rd_word = {RegAddr, ALUCode, Reg_CE, CY_CE, A_CE, ResetCY};

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [10:0] model_mem [DEPTH];
    logic [7:0]  sq [$];

    typedef struct {
        logic [7:0]  n;
        logic [7:0]  lo0, hi0, lo1, hi1;
        bit          exp_done;
        bit          exp_err;
        logic [10:0] exp_w0, exp_w1;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1; load_start = 1'b0; byte_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_nreset", 32'(cpu_nReset), 32'd0);
        check("rst_busy",   32'(load_busy),  32'd0);
        check("rst_ready",  32'(byte_ready), 32'd0);
        check("rst_done",   32'(load_done),  32'd0);
        check("rst_err",    32'(load_err),   32'd0);
        Reset = 1'b0;
        @(negedge clk);
        check("post_rst_nreset", 32'(cpu_nReset), 32'd1);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = DEF;
    endtask

    task automatic check_store(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            addr = ADDR_W'(a);
            #1;
            check($sformatf("%s[%0d]", tag, a), 32'(rd_word), 32'(model_mem[a]));
        end
        @(negedge clk);
    endtask

    task automatic start_load();
        byte_valid = 1'b0;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        check("start_err_clr", 32'(load_err),  32'd0);
        check("start_busy",    32'(load_busy), 32'd1);
    endtask

    // Presents one byte after a random idle gap and holds it until it is taken.
    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int cnt;
        repeat ($urandom_range(0, gap_max)) begin
            byte_in = 8'($urandom);
            @(negedge clk);
        end
        byte_in = b; byte_valid = 1'b1; cnt = 0;
        while (byte_ready !== 1'b1 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 50) begin
            n_checks++; n_fail++;
            $display("FAIL byte_timeout: byte 0x%0h not accepted, required within 50 cycles", b);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_range(input int from, input int to, input int gap_max);
        for (int i = from; i < to; i++) send_byte(sq[i], gap_max);
    endtask

    task automatic wait_end(output bit done_seen);
        int cnt = 0;
        done_seen = 1'b0;
        while (cnt < 20) begin
            if (load_done === 1'b1) done_seen = 1'b1;
            if (load_busy === 1'b0) break;
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 20) begin
            n_checks++; n_fail++;
            $display("FAIL end_timeout: load_busy=%0b, required 0 within 20 cycles", load_busy);
        end
    endtask

    // Interprets a byte stream by the format rules; returns bytes the loader will take.
    task automatic model_load(input logic [7:0] q[$], output int consumed,
                              output bit done, output bit err);
        logic [7:0] x;
        int n;
        done = 1'b0; err = 1'b0;
        n = int'(q[0]); x = q[0]; consumed = 1;
        if (n == 0 || n > int'(DEPTH)) begin
            err = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            consumed += 2;
            x ^= q[1+2*i] ^ q[2+2*i];
            if (q[2+2*i][7:3] != 5'd0) begin
                err = 1'b1;
                return;
            end
            model_mem[i] = {q[2+2*i][2:0], q[1+2*i]};
        end
`ifdef UCODE_CHECKSUM_EN
        consumed += 1;
        if (q[1+2*n] != x) begin
            err = 1'b1;
            return;
        end
`endif
        done = 1'b1;
    endtask

    // Stream of words plus a trailing checksum byte (sent only when the loader wants it).
    task automatic build(input logic [7:0] n, input logic [10:0] w[$], input bit bad_chk);
        logic [7:0] x;
        sq.delete();
        sq.push_back(n);
        x = n;
        foreach (w[i]) begin
            sq.push_back(w[i][7:0]);
            sq.push_back({5'd0, w[i][10:8]});
            x ^= w[i][7:0] ^ {5'd0, w[i][10:8]};
        end
        sq.push_back(bad_chk ? ~x : x);
    endtask

    task automatic run_and_check(input string tag, input int gap_max);
        int  consumed;
        bit  e_done, e_err, done_seen;
        model_load(sq, consumed, e_done, e_err);
        start_load();
        send_range(0, consumed, gap_max);
        wait_end(done_seen);
        check({tag, "_done"},   32'(done_seen),  32'(e_done));
        check({tag, "_err"},    32'(load_err),   32'(e_err));
        check({tag, "_nreset"}, 32'(cpu_nReset), 32'(!e_err));
        check_store(tag);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] wq [$];
        logic [7:0]  x;
        int          consumed, k;
        bit          e_done, e_err, done_seen;

        vecs[0] = '{8'h02, 8'h01, 8'h04, 8'hFF, 8'h00, 1'b1, 1'b0, 11'h401, 11'h0FF};
        vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, DEF,     DEF};
        vecs[2] = '{8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, DEF,     DEF};
        vecs[3] = '{8'h02, 8'h01, 8'h04, 8'hFF, 8'h08, 1'b0, 1'b1, 11'h401, DEF};
        vecs[4] = '{8'h01, 8'hAA, 8'h05, 8'h00, 8'h00, 1'b1, 1'b0, 11'h5AA, DEF};
        vecs[5] = '{8'h02, 8'h33, 8'h80, 8'h00, 8'h00, 1'b0, 1'b1, DEF,     DEF};
        vecs[6] = '{8'h02, 8'h55, 8'h07, 8'hAA, 8'h02, 1'b1, 1'b0, 11'h755, 11'h2AA};

        Reset = 1'b1; load_start = 1'b0; byte_valid = 1'b0; byte_in = 8'd0; addr = '0;
        @(negedge clk);

        // Reset contents.
        do_reset();
        check_store("rst");

        // Directed vector table.
        foreach (vecs[v]) begin
            do_reset();
            k = (vecs[v].n >= 8'd1 && vecs[v].n <= 8'd2) ? int'(vecs[v].n) : 0;
            sq.delete();
            sq.push_back(vecs[v].n);
            if (k >= 1) begin sq.push_back(vecs[v].lo0); sq.push_back(vecs[v].hi0); end
            if (k == 2) begin sq.push_back(vecs[v].lo1); sq.push_back(vecs[v].hi1); end
            x = 8'd0;
            foreach (sq[i]) x ^= sq[i];
            sq.push_back(x);
            model_load(sq, consumed, e_done, e_err);
            start_load();
            send_range(0, consumed, 1);
            wait_end(done_seen);
            check($sformatf("vec%0d_done", v), 32'(done_seen), 32'(vecs[v].exp_done));
            check($sformatf("vec%0d_err", v),  32'(load_err),  32'(vecs[v].exp_err));
            addr = ADDR_W'(0); #1;
            check($sformatf("vec%0d_w0", v), 32'(rd_word), 32'(vecs[v].exp_w0));
            addr = ADDR_W'(1); #1;
            check($sformatf("vec%0d_w1", v), 32'(rd_word), 32'(vecs[v].exp_w1));
            @(negedge clk);
        end

        // Write/read collision in WR and cpu_nReset release after DONE.
        do_reset();
        wq = '{11'h401, 11'h0FF};
        build(8'h02, wq, 1'b0);
        start_load();
        send_range(0, 4, 0);
        addr = ADDR_W'(1);
        send_byte(sq[4], 0);
        check("wr_old", 32'(rd_word), 32'(DEF));
        @(negedge clk);
        check("wr_new", 32'(rd_word), 32'h0FF);
`ifdef UCODE_CHECKSUM_EN
        send_byte(sq[5], 0);
`endif
        check("done_pulse",     32'(load_done),  32'd1);
        check("done_nreset_lo", 32'(cpu_nReset), 32'd0);
        @(negedge clk);
        check("done_clr",       32'(load_done),  32'd0);
        check("after_nreset",   32'(cpu_nReset), 32'd1);
        check("after_busy",     32'(load_busy),  32'd0);
        model_mem[0] = 11'h401;
        model_mem[1] = 11'h0FF;
        check_store("t2");

        // Bad count bytes keep the loaded program.
        start_load();
        send_byte(8'h00, 0);
        check("cnt0_err",    32'(load_err),   32'd1);
        check("cnt0_nreset", 32'(cpu_nReset), 32'd0);
        check_store("cnt0");
        start_load();
        send_byte(8'h21, 0);
        check("cnt21_err",   32'(load_err),   32'd1);
        check_store("cnt21");

        // Gappy stream with an ignored load_start pulse mid-load.
        do_reset();
        wq.delete();
        for (int i = 0; i < 5; i++) wq.push_back(11'($urandom));
        build(8'd5, wq, 1'b0);
        model_load(sq, consumed, e_done, e_err);
        start_load();
        send_range(0, 4, 3);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        send_range(4, consumed, 3);
        wait_end(done_seen);
        check("mid_start_done", 32'(done_seen), 32'd1);
        check("mid_start_err",  32'(load_err),  32'd0);
        check_store("mid_start");

        // Reset while word 3 is in flight.
        wq.delete();
        for (int i = 0; i < 6; i++) wq.push_back(11'($urandom));
        build(8'd6, wq, 1'b0);
        start_load();
        send_range(0, 8, 2);
        do_reset();
        check_store("rst_mid");

`ifdef UCODE_CHECKSUM_EN
        // Corrupted checksum: words stay written, load flagged.
        wq = '{11'h123, 11'h456, 11'h789};
        build(8'd3, wq, 1'b1);
        run_and_check("badchk", 1);
        build(8'd3, wq, 1'b0);
        run_and_check("goodchk", 1);
`endif

        // Randomized loads against the stream model; store persists between loads.
        for (int it = 0; it < 25; it++) begin
            int sel, n;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      n = 0;
            else if (sel == 1) n = int'($urandom_range(33, 255));
            else               n = int'($urandom_range(1, 32));
            wq.delete();
            for (int i = 0; i < ((n <= 32) ? n : 0); i++) wq.push_back(11'($urandom));
            build(8'(n), wq, ($urandom_range(0, 5) == 0));
            if (n >= 1 && n <= 32 && $urandom_range(0, 5) == 0) begin
                k = int'($urandom_range(0, n - 1));
                sq[2+2*k] = sq[2+2*k] | (8'h08 << $urandom_range(0, 4));
            end
            run_and_check($sformatf("rnd%0d", it), 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
